stage_fetch: RTL and testbench

- Front pipeline stage. Drives the PC, issues word fetches to the instruction memory port, and buffers returned instructions in a small FIFO.
- Presents instructions to decode on de_valid/de_insn/de_pc, holding them under de_stall.
- Accepts redirects (jump/taken branch) from the mem stage, squashing buffered and in-flight fetches.

---
 rtl/stage_fetch_pkg.sv | 16 +
 rtl/stage_fetch_if.sv | 27 ++
 rtl/stage_fetch_fifo.sv | 71 +++++++
 rtl/stage_fetch.sv | 123 ++++++++++++
 tb/tb_stage_fetch.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stage_fetch_pkg.sv
// Shared fetch-stage constants and the instruction-buffer entry layout.
// Optional feature macro used by this slice: FETCH_ALIGN_CHECK_EN.
package stage_fetch_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned INSN_W = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INSN_W-1:0] insn;
    } fetch_entry_t;

endpackage

// File: rtl/stage_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface stage_fetch_if;
    import stage_fetch_pkg::*;

    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [XLEN-1:0]   imem_req_addr;
    logic              imem_resp_valid;
    logic [INSN_W-1:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );

endinterface

// File: rtl/stage_fetch_fifo.sv
// fetch_fifo: small synchronous FIFO with flush; flush beats push and pop.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop, full;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i & ~flush_i;
    assign do_pop  = pop_i & ~flush_i & (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Owners size their credits so a push never lands on a full, non-popping FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(do_push && full && !do_pop));

endmodule

// File: rtl/stage_fetch.sv
// Fetch stage: PC generation, imem request issue with credit control, instruction buffer.
// Optional misaligned-redirect fault when FETCH_ALIGN_CHECK_EN is defined.
module stage_fetch
    import stage_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter int unsigned     BUF_DEPTH       = 2
) (
    input  logic              clk,
    input  logic              reset,
    stage_fetch_if.master     imem,
    input  logic              mem_redirect,
    input  logic [XLEN-1:0]   mem_redirect_pc,
    input  logic              de_stall,
    output logic              de_valid,
    output logic [INSN_W-1:0] de_insn,
    output logic [XLEN-1:0]   de_pc,
    output logic              fe_fault
);

    localparam int unsigned CW      = $clog2(MAX_OUTSTANDING + BUF_DEPTH + 1) + 1;
    localparam int unsigned TAG_CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned IBUF_CW = $clog2(BUF_DEPTH + 1);

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [CW-1:0]      drop_q, drop_d;
    logic               fault_q, fault_d;

    logic [TAG_CW-1:0]  tag_count;
    logic [XLEN-1:0]    tag_pc;
    logic [IBUF_CW-1:0] ibuf_count;
    fetch_entry_t       ibuf_in, ibuf_head;

    logic [CW-1:0]      outst, live;
    logic               issue_ok, accept, resp_live;
    logic               redirect_bad;
    logic [XLEN-1:0]    redirect_tgt;

`ifdef FETCH_ALIGN_CHECK_EN
    assign redirect_bad = mem_redirect & (mem_redirect_pc[1:0] != 2'b00);
    assign redirect_tgt = mem_redirect_pc;
`else
    assign redirect_bad = 1'b0;
    assign redirect_tgt = mem_redirect_pc & ~32'h3;
`endif

    // The tag queue holds exactly one entry per accepted, unanswered request.
    assign outst = CW'(tag_count);
    assign live  = outst - drop_q + CW'(ibuf_count);

    assign issue_ok = ~reset & ~mem_redirect & ~fault_q
                    & (outst < CW'(MAX_OUTSTANDING))
                    & (live < CW'(BUF_DEPTH));
    assign accept   = issue_ok & imem.imem_req_ready;

    assign imem.imem_req_valid = issue_ok;
    assign imem.imem_req_addr  = pc_q;

    assign resp_live = imem.imem_resp_valid & (drop_q == '0) & ~mem_redirect;

    always_comb begin
        pc_d    = pc_q;
        drop_d  = drop_q;
        fault_d = fault_q | redirect_bad;
        if (mem_redirect) begin
            pc_d   = redirect_tgt;
            drop_d = outst - CW'(imem.imem_resp_valid);
        end else begin
            if (accept) pc_d = pc_q + PC_INC;
            if (imem.imem_resp_valid && (drop_q != '0)) drop_d = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            drop_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            fault_q <= fault_d;
        end
    end

    // Tags are never flushed: stale responses still retire their own tag.
    fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (XLEN)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (1'b0),
        .push_i  (accept),
        .data_i  (pc_q),
        .pop_i   (imem.imem_resp_valid),
        .data_o  (tag_pc),
        .count_o (tag_count)
    );

    assign ibuf_in = '{pc: tag_pc, insn: imem.imem_resp_data};

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_ibuf (
        .clk     (clk),
        .reset   (reset),
        .flush_i (mem_redirect),
        .push_i  (resp_live),
        .data_i  (ibuf_in),
        .pop_i   (~de_stall),
        .data_o  (ibuf_head),
        .count_o (ibuf_count)
    );

    assign de_valid = (ibuf_count != '0);
    assign de_insn  = ibuf_head.insn;
    assign de_pc    = ibuf_head.pc;
    assign fe_fault = fault_q;

endmodule

// File: tb/tb_stage_fetch.sv
// Scoreboard bench for stage_fetch with an in-order, variable-latency imem model.
module tb_stage_fetch;
    import stage_fetch_pkg::*;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        mem_redirect;
    logic [31:0] mem_redirect_pc;
    logic        de_stall;
    logic        de_valid;
    logic [31:0] de_insn;
    logic [31:0] de_pc;
    logic        fe_fault;

    stage_fetch_if imem ();

    stage_fetch #(
        .RESET_PC        (32'h0000_0000),
        .MAX_OUTSTANDING (2),
        .BUF_DEPTH       (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem            (imem),
        .mem_redirect    (mem_redirect),
        .mem_redirect_pc (mem_redirect_pc),
        .de_stall        (de_stall),
        .de_valid        (de_valid),
        .de_insn         (de_insn),
        .de_pc           (de_pc),
        .fe_fault        (fe_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mreq_t       memq [$];
    exp_t        sb [$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned n_pops = 0;
    int unsigned stall_left = 0;
    int unsigned ready_left = 0;
    int          first_acc = -1;
    int          first_dv = -1;

    logic [31:0] exp_pc = 32'h0;
    logic [31:0] key = 32'h0;
    logic [31:0] stall_pc = 32'd8;
    logic [31:0] redir_first_pc = 32'h0;
    logic [31:0] busy_tgt = 32'h0;
    logic [31:0] in_redir_pc = 32'h0;
    bit in_reset = 1'b1, in_redir = 1'b0;
    bit stall_arm = 1'b0, ready_arm = 1'b0, busy_arm = 1'b0;
    bit first_pending = 1'b0, after_redir = 1'b0, issue_after = 1'b0;
    bit fault_exp = 1'b0, saw_drop = 1'b0, saw_valid_nr = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: drive this cycle's inputs after the edge, then check and update the model.
    task automatic step();
        bit          was_reset, stall_now, ready_now, redir_now, busy_now, bad;
        logic [31:0] redir_pc_now;
        mreq_t       m;
        exp_t        e;

        @(posedge clk);
        #1;
        cyc++;
        was_reset = reset;
        busy_now  = 1'b0;

        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = '0;
        if (!in_reset && memq.size() != 0 && memq[0].due <= cyc) begin
            imem.imem_resp_valid = 1'b1;
            imem.imem_resp_data  = memq[0].data;
            void'(memq.pop_front());
        end

        if (ready_arm && !stall_arm && stall_left == 0 && exp_pc == 32'd16) begin
            ready_arm  = 1'b0;
            ready_left = 3;
        end
        ready_now = (ready_left == 0);
        if (ready_left != 0) ready_left--;

        if (stall_arm && de_valid && de_pc == stall_pc) begin
            stall_arm  = 1'b0;
            stall_left = 5;
        end
        stall_now = (stall_left != 0);
        if (stall_left != 0) stall_left--;

        redir_now    = in_redir;
        redir_pc_now = in_redir_pc;
        if (busy_arm && imem.imem_resp_valid && de_valid && !stall_now) begin
            busy_arm     = 1'b0;
            busy_now     = 1'b1;
            redir_now    = 1'b1;
            redir_pc_now = busy_tgt;
        end

        reset                = in_reset;
        mem_redirect         = redir_now;
        mem_redirect_pc      = redir_pc_now;
        de_stall             = stall_now;
        imem.imem_req_ready  = ready_now;
        #1;

        if (reset) begin
            check_eq("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
            if (was_reset) begin
                check_eq("rst_de_valid", 32'(de_valid), 32'd0);
                check_eq("rst_fe_fault", 32'(fe_fault), 32'd0);
            end
            memq.delete();
            sb.delete();
            exp_pc        = 32'h0;
            fault_exp     = 1'b0;
            first_pending = 1'b0;
            after_redir   = 1'b0;
            issue_after   = 1'b0;
        end else begin
            check_eq("fe_fault", 32'(fe_fault), 32'(fault_exp));
            if (after_redir) check_eq("flush_de_valid", 32'(de_valid), 32'd0);
            if (issue_after) begin
                check_eq("redir_issue_valid", 32'(imem.imem_req_valid), 32'd1);
                check_eq("redir_issue_addr", imem.imem_req_addr, busy_tgt);
            end
            if (stall_now) begin
                check_eq("stall_pc", de_pc, stall_pc);
                if (!imem.imem_req_valid) saw_drop = 1'b1;
            end
            if (!ready_now) begin
                check_eq("hold_addr", imem.imem_req_addr, 32'd16);
                if (imem.imem_req_valid) saw_valid_nr = 1'b1;
            end
            if (fault_exp) begin
                check_eq("fault_req_valid", 32'(imem.imem_req_valid), 32'd0);
                check_eq("fault_de_valid", 32'(de_valid), 32'd0);
            end
            if (redir_now) check_eq("redir_req_valid", 32'(imem.imem_req_valid), 32'd0);

            if (de_valid) begin
                if (first_acc >= 0 && first_dv < 0) first_dv = int'(cyc);
                if (first_pending) begin
                    check_eq("redir_first_pc", de_pc, redir_first_pc);
                    first_pending = 1'b0;
                end
                if (sb.size() == 0) begin
                    check_eq("unexpected_de_valid", 32'(de_valid), 32'd0);
                end else begin
                    check_eq("de_pc", de_pc, sb[0].pc);
                    check_eq("de_insn", de_insn, sb[0].insn);
                    if (!stall_now && !redir_now) begin
                        void'(sb.pop_front());
                        n_pops++;
                    end
                end
            end

            if (imem.imem_req_valid && ready_now) begin
                if (first_acc < 0) first_acc = int'(cyc);
                check_eq("req_addr", imem.imem_req_addr, exp_pc);
                m.data = imem.imem_req_addr ^ key;
                m.due  = cyc + lat;
                memq.push_back(m);
                e.pc   = imem.imem_req_addr;
                e.insn = imem.imem_req_addr ^ key;
                sb.push_back(e);
                exp_pc = exp_pc + 32'd4;
            end

            after_redir = redir_now;
            issue_after = busy_now;
            if (redir_now) begin
                sb.delete();
`ifdef FETCH_ALIGN_CHECK_EN
                bad = (redir_pc_now[1:0] != 2'b00);
`else
                bad = 1'b0;
`endif
                if (bad) begin
                    fault_exp = 1'b1;
                end else begin
                    exp_pc         = redir_pc_now & ~32'h3;
                    redir_first_pc = redir_pc_now & ~32'h3;
                    first_pending  = 1'b1;
                end
            end
        end
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        in_redir    = 1'b1;
        in_redir_pc = tgt;
        step();
        in_redir    = 1'b0;
    endtask

    task automatic wait_outstanding2(input string tag);
        for (int i = 0; i < 30 && memq.size() != 2; i++) step();
        check_eq(tag, 32'(memq.size()), 32'd2);
    endtask

    task automatic wait_pops(input string tag, input int unsigned n);
        int unsigned target;
        target = n_pops + n;
        for (int i = 0; i < 60 && n_pops < target; i++) step();
        check_eq(tag, 32'(n_pops >= target), 32'd1);
    endtask

    initial begin
        reset                = 1'b1;
        mem_redirect         = 1'b0;
        mem_redirect_pc      = '0;
        de_stall             = 1'b0;
        imem.imem_req_ready  = 1'b1;
        imem.imem_resp_valid = 1'b0;
        imem.imem_resp_data  = '0;

        repeat (3) step();
        in_reset  = 1'b0;

        // Addr-as-data stream, stall at pc 8, then imem back-pressure at pc 16.
        stall_arm = 1'b1;
        ready_arm = 1'b1;
        for (int i = 0; i < 80 && (stall_arm || stall_left != 0 || ready_arm || ready_left != 0); i++)
            step();
        check_eq("stall_trigger_seen", 32'(stall_arm), 32'd0);
        check_eq("ready_trigger_seen", 32'(ready_arm), 32'd0);
        check_eq("first_latency", 32'(first_dv - first_acc), 32'd2);
        check_eq("stall_credit_drop", 32'(saw_drop), 32'd1);
        check_eq("notready_valid_held", 32'(saw_valid_nr), 32'd1);
        wait_pops("drain_after_hold", 4);

        // Stale responses at 3-cycle latency must be dropped.
        key = 32'h5A5A_0000;
        lat = 3;
        wait_outstanding2("outst2_a");
        redirect_to(32'h0000_0100);
        wait_pops("redir_100", 2);

        // Redirect coinciding with a response and a decode pop.
        lat = 1;
        repeat (6) step();
        busy_tgt = 32'h0000_0200;
        busy_arm = 1'b1;
        for (int i = 0; i < 40 && busy_arm; i++) step();
        check_eq("busy_redirect_seen", 32'(busy_arm), 32'd0);
        wait_pops("redir_200", 2);

        // Back-to-back redirects: the later target wins.
        lat = 3;
        wait_outstanding2("outst2_b");
        redirect_to(32'h0000_0300);
        redirect_to(32'h0000_0400);
        wait_pops("redir_400", 3);

        // PC wrap past the top of the address space.
        lat = 1;
        redirect_to(32'hFFFF_FFF8);
        wait_pops("wrap", 4);

        // Misaligned redirect target.
        redirect_to(32'h0000_0102);
`ifdef FETCH_ALIGN_CHECK_EN
        repeat (10) step();
        check_eq("fault_sticky", 32'(fe_fault), 32'd1);
`else
        wait_pops("misaligned_100", 2);
        check_eq("no_fault", 32'(fe_fault), 32'd0);
`endif

        // Reset in the middle of traffic, then restart from RESET_PC.
        lat = 3;
        repeat (3) step();
        in_reset = 1'b1;
        repeat (2) step();
        in_reset = 1'b0;
        wait_pops("after_reset", 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
